risc_wb_arbiter: RTL

- Owns the single register-file write port.
- Shares that port between two sources:
  - the in-order pipeline write-back result (Bus_D / RW_1 / DA_1);
  - results from a long-latency unit (multiply/divide), held in a small result FIFO.
- Keeps a busy scoreboard of registers with an outstanding long-latency result, and drives issue-accept and hazard-stall signals to decode.

---
 rtl/risc_wb_arbiter_pkg.sv | 27 ++
 rtl/risc_wb_fifo.sv | 74 +++++++
 rtl/risc_wb_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/risc_wb_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module      : risc_wb_arbiter_pkg
// Description : Shared widths, constants and the write-back request type
//               used by the register-file write-port arbiter and its FIFO.
// Revision    : 1.0 - initial release
//============================================================================
package risc_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One register-file write: destination register and the value to write
    typedef struct packed {
        logic [REG_ADDR_W-1:0] da;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // Register 0 is hard-wired, so any write or busy mark aimed at it is dropped
    function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] addr);
        return (addr == REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc_wb_fifo.sv
`default_nettype none
//============================================================================
// Module      : risc_wb_fifo
// Description : Synchronous FIFO holding long-latency results waiting for
//               the register-file write port. Head entry is visible
//               combinationally; full/empty/count come from registered state.
// Revision    : 1.0 - initial release
//============================================================================
module risc_wb_fifo
    import risc_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  wb_req_t                         wr_data,
    input  logic                            rd_en,
    output wb_req_t                         rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(FIFO_DEPTH);

    wb_req_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_wr;
    logic               w_rd;

    // Overflowing writes and underflowing reads are ignored
    assign w_wr    = wr_en && (r_count != c_full_cnt);
    assign w_rd    = rd_en && (r_count != '0);

    assign full    = (r_count == c_full_cnt);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/risc_wb_arbiter.sv
`default_nettype none
//============================================================================
// Module      : risc_wb_arbiter
// Description : Owns the register-file write port and shares it between the
//               in-order pipeline write-back and queued long-latency results.
//               Tracks registers with outstanding long-latency results and
//               drives issue-accept / hazard-stall back to decode.
// Revision    : 1.0 - initial release
//============================================================================
module risc_wb_arbiter
    import risc_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pl_rw,
    input  logic [REG_ADDR_W-1:0] pl_da,
    input  logic [DATA_W-1:0]     pl_bus_d,
    output logic                  pl_hold,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_da,
    input  logic [DATA_W-1:0]     lu_data,
    output logic                  lu_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_da,
    output logic                  iss_accept,
    input  logic [REG_ADDR_W-1:0] chk_aa,
    input  logic [REG_ADDR_W-1:0] chk_ba,
    output logic                  stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_da,
    output logic [DATA_W-1:0]     rf_d
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] c_starve_max = STV_W'(STARVE_MAX);

    wb_req_t               w_lu_req;
    wb_req_t               w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic                  w_push;
    logic                  w_fifo_req;
    logic                  w_starved;
    logic                  w_fifo_win;

    logic [STV_W-1:0]      r_starve_cnt;
    logic [31:0]           r_busy;
    logic [31:0]           w_busy_set;
    logic [31:0]           w_busy_clr;
    logic [31:0]           w_busy_nxt;

    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_da;
    logic [DATA_W-1:0]     r_rf_d;

    assign w_lu_req.da   = lu_da;
    assign w_lu_req.data = lu_data;

    // Readiness depends only on registered occupancy: a same-cycle pop never frees a slot
    assign lu_ready = !w_full;
    assign w_push   = lu_valid && !w_full;

    risc_wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_push),
        .wr_data (w_lu_req),
        .rd_en   (w_fifo_win),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Pipeline has priority unless it is idle or the FIFO head has lost too often
    assign w_fifo_req = (w_count != '0);
    assign w_starved  = (r_starve_cnt == c_starve_max);
    assign w_fifo_win = w_fifo_req && (!pl_rw || w_starved);
    assign pl_hold    = pl_rw && w_fifo_win;

    // Decode-facing hazard view of the scoreboard; r0 can never be pending
    assign iss_accept = !r_busy[iss_da];
    assign stall      = (!is_reg_zero(chk_aa) && r_busy[chk_aa]) ||
                        (!is_reg_zero(chk_ba) && r_busy[chk_ba]) ||
                        (pl_rw && !is_reg_zero(pl_da) && r_busy[pl_da]);

    // Scoreboard next state: retire on pop, mark on accepted issue, set beats clear
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (w_fifo_win && !is_reg_zero(w_head.da)) begin
            w_busy_clr[w_head.da] = 1'b1;
        end
        if (iss_valid && iss_accept && !is_reg_zero(iss_da)) begin
            w_busy_set[iss_da] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Count consecutive losses of a waiting FIFO head, saturating at the force threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_empty || w_fifo_win) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + STV_W'(1);
        end
    end

    // Register the winning write; address/data hold when nobody requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we <= 1'b0;
            r_rf_da <= '0;
            r_rf_d  <= '0;
        end else if (w_fifo_win) begin
            r_rf_we <= !is_reg_zero(w_head.da);
            r_rf_da <= w_head.da;
            r_rf_d  <= w_head.data;
        end else if (pl_rw) begin
            r_rf_we <= !is_reg_zero(pl_da);
            r_rf_da <= pl_da;
            r_rf_d  <= pl_bus_d;
        end else begin
            r_rf_we <= 1'b0;
        end
    end

    assign rf_we = r_rf_we;
    assign rf_da = r_rf_da;
    assign rf_d  = r_rf_d;

endmodule
`default_nettype wire
